zmenu_navigator: RTL and testbench

- Parametrised successor to the four-button cursor adapter for the TFT43 menu.
- Takes raw push-button levels and performs synchronisation, per-button debounce, press-edge detection and hold auto-repeat.
- Drives a two-mode menu FSM: BROWSE moves a wrapping cursor over NUM_ITEMS entries; EDIT adjusts a per-item value such as the SIN period count.
- Sits between the board buttons and the LCD draw/waveform logic, which consume the committed index/value and a one-cycle commit pulse.

---
 rtl/zmenu_navigator_if.sv | 24 ++
 rtl/zmenu_navigator.sv | 202 ++++++++++++++++++++
 tb/tb_zmenu_navigator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/zmenu_navigator_if.sv
// rtl/zmenu_navigator_if.sv - button/menu bus between board buttons and the menu navigator
interface zmenu_navigator_if #(
    parameter int IDX_W = 4,
    parameter int VAL_W = 3
);
    logic [3:0]       iButton;
    logic [IDX_W-1:0] oCursor_Index;
    logic             oEdit_Mode;
    logic [VAL_W-1:0] oValue;
    logic [IDX_W-1:0] oSel_Index;
    logic [VAL_W-1:0] oValue_Commit;
    logic             oCommit;
    logic             oAbort;

    modport slave (
        input  iButton,
        output oCursor_Index, oEdit_Mode, oValue, oSel_Index, oValue_Commit, oCommit, oAbort
    );

    modport master (
        output iButton,
        input  oCursor_Index, oEdit_Mode, oValue, oSel_Index, oValue_Commit, oCommit, oAbort
    );
endinterface

// File: rtl/zmenu_navigator.sv
// rtl/zmenu_navigator.sv - debounced four-button menu cursor/edit FSM with hold auto-repeat
module zmenu_navigator #(
    parameter int NUM_ITEMS       = 11,
    parameter int IDX_W           = 4,
    parameter int VAL_W           = 3,
    parameter int MAX_VALUE       = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1250000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    zmenu_navigator_if.slave bus
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRE   = RPT_W'(REPEAT_DELAY);
    // After a repeat the counter restarts so the next fire is REPEAT_PERIOD cycles later.
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_ITEMS - 1);
    localparam logic [VAL_W-1:0] VAL_MAX    = VAL_W'(MAX_VALUE);

    localparam logic [1:0] BROWSE = 2'b00;
    localparam logic [1:0] EDIT   = 2'b01;

    logic [3:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]            acc_q, acc_d, acc_prev_q, acc_prev_d;
    logic [3:0][CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [3:0]            press;
    logic [1:0]            rpt;
    logic [3:0]            ev;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] cursor_q, cursor_d, sel_q, sel_d;
    logic [VAL_W-1:0] value_q, value_d, vcommit_q, vcommit_d;
    logic             commit_q, commit_d, abort_q, abort_d;

    // Synchronise, then accept a new level only after it has been stable long enough.
    always_comb begin
        sync1_d    = bus.iButton;
        sync2_d    = sync1_q;
        acc_d      = acc_q;
        acc_prev_d = acc_q;
        db_cnt_d   = db_cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] != acc_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    acc_d[i]    = ~acc_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
        if (!en) begin
            sync1_d    = '0;
            sync2_d    = '0;
            acc_d      = '0;
            acc_prev_d = '0;
            db_cnt_d   = '0;
        end
    end

    // Input path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_q      <= acc_d;
            acc_prev_q <= acc_prev_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign press = acc_q & ~acc_prev_q;

    // Hold auto-repeat for Prev/Next: counter value equals cycles elapsed since the press.
    always_comb begin
        rpt       = '0;
        rpt_cnt_d = rpt_cnt_q;
        for (int i = 0; i < 2; i++) begin
            rpt[i] = acc_q[i] && (rpt_cnt_q[i] == RPT_FIRE);
            if (press[i]) begin
                rpt_cnt_d[i] = RPT_W'(1);
            end else if (!acc_q[i]) begin
                rpt_cnt_d[i] = '0;
            end else if (rpt[i]) begin
                rpt_cnt_d[i] = RPT_RELOAD;
            end else begin
                rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
        end
        if (!en) begin
            rpt_cnt_d = '0;
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign ev = press | {2'b00, rpt};

    // Menu FSM: one event per cycle, Cancel > Okay > Prev > Next.
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        sel_d     = sel_q;
        value_d   = value_q;
        vcommit_d = vcommit_q;
        commit_d  = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            BROWSE: begin
                if (ev[3]) begin
                    cursor_d = sel_q;
                end else if (ev[2]) begin
                    state_d = EDIT;
                    value_d = vcommit_q;
                end else if (ev[0]) begin
                    cursor_d = (cursor_q == '0) ? IDX_LAST : cursor_q - 1'b1;
                end else if (ev[1]) begin
                    cursor_d = (cursor_q == IDX_LAST) ? '0 : cursor_q + 1'b1;
                end
            end
            EDIT: begin
                if (ev[3]) begin
                    value_d = vcommit_q;
                    abort_d = 1'b1;
                    state_d = BROWSE;
                end else if (ev[2]) begin
                    sel_d     = cursor_q;
                    vcommit_d = value_q;
                    commit_d  = 1'b1;
                    state_d   = BROWSE;
                end else if (ev[0]) begin
                    if (value_q != '0) value_d = value_q - 1'b1;
                end else if (ev[1]) begin
                    if (value_q != VAL_MAX) value_d = value_q + 1'b1;
                end
            end
            default: begin
                state_d = BROWSE;
            end
        endcase
        if (!en) begin
            state_d   = BROWSE;
            cursor_d  = '0;
            sel_d     = '0;
            value_d   = '0;
            vcommit_d = '0;
            commit_d  = 1'b0;
            abort_d   = 1'b0;
        end
    end

    // Menu state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BROWSE;
            cursor_q  <= '0;
            sel_q     <= '0;
            value_q   <= '0;
            vcommit_q <= '0;
            commit_q  <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            sel_q     <= sel_d;
            value_q   <= value_d;
            vcommit_q <= vcommit_d;
            commit_q  <= commit_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.oCursor_Index = cursor_q;
    assign bus.oEdit_Mode    = (state_q == EDIT);
    assign bus.oValue        = value_q;
    assign bus.oSel_Index    = sel_q;
    assign bus.oValue_Commit = vcommit_q;
    assign bus.oCommit       = commit_q;
    assign bus.oAbort        = abort_q;
endmodule

// File: tb/tb_zmenu_navigator.sv
// tb/tb_zmenu_navigator.sv - directed table-driven bench for zmenu_navigator
module tb_zmenu_navigator;
    localparam logic [3:0] B_P = 4'b0001;
    localparam logic [3:0] B_N = 4'b0010;
    localparam logic [3:0] B_O = 4'b0100;
    localparam logic [3:0] B_C = 4'b1000;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    zmenu_navigator_if #(.IDX_W(4), .VAL_W(3)) bus ();

    zmenu_navigator #(
        .NUM_ITEMS(11), .IDX_W(4), .VAL_W(3), .MAX_VALUE(4),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(16), .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        int cur; int edit; int val; int sel; int vc; int ncommit; int nabort;
    } vec_t;

    vec_t tbl [23];
    int checks = 0;
    int errors = 0;
    int commit_cnt = 0;
    int abort_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (bus.oCommit) commit_cnt++;
        if (bus.oAbort) abort_cnt++;
        if (bus.oCommit && bus.oAbort) both_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int cur, input int edit, input int val,
                           input int sel, input int vc);
        chk({tag, ".cursor"}, int'(bus.oCursor_Index), cur);
        chk({tag, ".edit"}, int'(bus.oEdit_Mode), edit);
        chk({tag, ".value"}, int'(bus.oValue), val);
        chk({tag, ".sel"}, int'(bus.oSel_Index), sel);
        chk({tag, ".vcommit"}, int'(bus.oValue_Commit), vc);
    endtask

    task automatic press_btn(input logic [3:0] b);
        bus.iButton = b;
        repeat (6) @(negedge clk);
        bus.iButton = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            press_btn(tbl[i].btn);
            chk_all(tag, tbl[i].cur, tbl[i].edit, tbl[i].val, tbl[i].sel, tbl[i].vc);
            chk({tag, ".commits"}, commit_cnt, tbl[i].ncommit);
            chk({tag, ".aborts"}, abort_cnt, tbl[i].nabort);
        end
    endtask

    initial begin
        // Wrap in both directions from cursor 1.
        tbl[0]  = '{B_P, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{B_P, 10, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{B_N, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{B_N, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{B_P, 0, 0, 0, 0, 0, 0, 0};
        // From cursor 5 after the hold sequence: edit, saturate, commit, abort, priority.
        tbl[5]  = '{B_P, 4, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{B_P, 3, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{B_O, 3, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{B_N, 3, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{B_N, 3, 1, 2, 0, 0, 0, 0};
        tbl[10] = '{B_N, 3, 1, 3, 0, 0, 0, 0};
        tbl[11] = '{B_N, 3, 1, 4, 0, 0, 0, 0};
        tbl[12] = '{B_N, 3, 1, 4, 0, 0, 0, 0};
        tbl[13] = '{B_N, 3, 1, 4, 0, 0, 0, 0};
        tbl[14] = '{B_O, 3, 0, 4, 3, 4, 1, 0};
        tbl[15] = '{B_O, 3, 1, 4, 3, 4, 1, 0};
        tbl[16] = '{B_P, 3, 1, 3, 3, 4, 1, 0};
        tbl[17] = '{B_P, 3, 1, 2, 3, 4, 1, 0};
        tbl[18] = '{B_C, 3, 0, 4, 3, 4, 1, 1};
        tbl[19] = '{B_O, 3, 1, 4, 3, 4, 1, 1};
        tbl[20] = '{B_O | B_C, 3, 0, 4, 3, 4, 1, 2};
        tbl[21] = '{B_O, 3, 1, 4, 3, 4, 1, 2};
        tbl[22] = '{B_P, 3, 1, 3, 3, 4, 1, 2};

        rst_n = 1'b0;
        en = 1'b1;
        bus.iButton = 4'b0000;
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset.commit", int'(bus.oCommit), 0);
        chk("reset.abort", int'(bus.oAbort), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3-cycle glitch must not be accepted.
        bus.iButton = B_N;
        repeat (3) @(negedge clk);
        bus.iButton = 4'b0000;
        repeat (12) @(negedge clk);
        chk("glitch.cursor", int'(bus.oCursor_Index), 0);

        // Clean 10-cycle press: moves exactly 2+4+1 edges after the raw edge.
        bus.iButton = B_N;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (t == 6) chk("latency.before", int'(bus.oCursor_Index), 0);
            if (t == 7) chk("latency.at", int'(bus.oCursor_Index), 1);
        end
        bus.iButton = 4'b0000;
        repeat (12) @(negedge clk);
        chk("clean.cursor", int'(bus.oCursor_Index), 1);

        run_table(0, 4);

        // Hold Next 46 cycles: press at edge 7, repeats land at edges 23, 31, 39, 47.
        bus.iButton = B_N;
        for (int t = 1; t <= 70; t++) begin
            @(negedge clk);
            if (t == 46) bus.iButton = 4'b0000;
            if (t == 7)  chk("hold.t7", int'(bus.oCursor_Index), 1);
            if (t == 22) chk("hold.t22", int'(bus.oCursor_Index), 1);
            if (t == 23) chk("hold.t23", int'(bus.oCursor_Index), 2);
            if (t == 31) chk("hold.t31", int'(bus.oCursor_Index), 3);
            if (t == 39) chk("hold.t39", int'(bus.oCursor_Index), 4);
            if (t == 47) chk("hold.t47", int'(bus.oCursor_Index), 5);
        end
        chk("hold.final", int'(bus.oCursor_Index), 5);

        run_table(5, 22);

        // en low for one cycle mid-EDIT clears everything.
        chk("en.pre_edit", int'(bus.oEdit_Mode), 1);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        chk_all("en_low", 0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);

        press_btn(B_O);
        press_btn(B_N);
        chk_all("pre_rst", 0, 1, 1, 0, 0);

        // Asynchronous reset takes effect before any clock edge.
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        chk("async_rst.commit", int'(bus.oCommit), 0);
        chk("async_rst.abort", int'(bus.oAbort), 0);
        chk("overlap.pulses", both_cnt, 0);
        chk("total.commits", commit_cnt, 1);
        chk("total.aborts", abort_cnt, 2);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
